// File: rtl/lc3_defs.sv
// Shared LC-3 definitions for the effective-address sequencer: opcodes,
// EAB select encodings, controller state encoding and the control-word layout.
package lc3_defs;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  localparam logic       EAB1_PC    = 1'b0;
  localparam logic       EAB1_REG   = 1'b1;
  localparam logic [1:0] EAB2_ZERO  = 2'b00;
  localparam logic [1:0] EAB2_OFF6  = 2'b01;
  localparam logic [1:0] EAB2_OFF9  = 2'b10;
  localparam logic [1:0] EAB2_OFF11 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_MEM1,
    ST_IND,
    ST_MEM2,
    ST_WB,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       sel_eab1;
    logic [1:0] sel_eab2;
    logic       ld_mar;
    logic       mar_src;
    logic       ld_pc;
    logic       ld_r7;
    logic       ld_reg;
    logic       mem_en;
    logic       mem_we;
    logic       busy;
    logic       done;
    logic       err;
  } ctrl_t;

  // {selEAB1, selEAB2} for an opcode; unsupported opcodes get all zeros.
  function automatic logic [2:0] eab_sel(input logic [3:0] op, input logic jsr_bit);
    case (op)
      OP_BR, OP_LD, OP_ST, OP_LDI, OP_STI, OP_LEA: eab_sel = {EAB1_PC, EAB2_OFF9};
      OP_LDR, OP_STR:                              eab_sel = {EAB1_REG, EAB2_OFF6};
      OP_JSR:  eab_sel = jsr_bit ? {EAB1_PC, EAB2_OFF11} : {EAB1_REG, EAB2_ZERO};
      OP_JMP:  eab_sel = {EAB1_REG, EAB2_ZERO};
      default: eab_sel = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/eab_seq_ctrl.sv
// Effective-address sequencer for LC-3 BR/JSR/JMP/LD/ST/LDR/STR/LDI/STI/LEA.
// Outputs are registered from the next state so they line up with the state cycle.
module eab_seq_ctrl
  import lc3_defs::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic [2:0]  nzp,
  input  logic        memReady,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        ldMAR,
  output logic        selMARsrc,
  output logic        ldPC,
  output logic        ldR7,
  output logic        ldReg,
  output logic        memEn,
  output logic        memWE,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t        r_state;
  logic [15:0]   r_irq;
  logic [CW-1:0] r_cnt;
  ctrl_t         r_ctrl;

  state_t        w_state_next;
  logic [15:0]   w_irq_next;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_abort;
  logic [3:0]    w_op;
  logic [3:0]    w_op_next;
  logic [2:0]    w_sel_next;
  ctrl_t         w_ctrl_next;

  assign w_op      = r_irq[15:12];
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_irq_next   = r_irq;
    w_cnt_next   = r_cnt;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_irq_next   = ir;
          w_state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        case (w_op)
          OP_BR, OP_JMP, OP_JSR, OP_LEA: w_state_next = ST_DONE;
          OP_LD, OP_ST, OP_LDR, OP_STR, OP_LDI, OP_STI: begin
            w_state_next = ST_MEM1;
            w_cnt_next   = '0;
          end
          default: w_state_next = ST_IDLE;
        endcase
      end
      ST_MEM1, ST_MEM2: begin
        if (memReady) begin
          if (r_state == ST_MEM1 && (w_op == OP_LDI || w_op == OP_STI))
            w_state_next = ST_IND;
          else if (w_op == OP_LD || w_op == OP_LDR || w_op == OP_LDI)
            w_state_next = ST_WB;
          else
            w_state_next = ST_DONE;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_state_next = ST_IDLE;
          w_abort      = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      ST_IND: begin
        w_state_next = ST_MEM2;
        w_cnt_next   = '0;
      end
      ST_WB:   w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Decode of the upcoming state; BR's condition uses nzp at the edge entering ADDR.
  assign w_op_next  = w_irq_next[15:12];
  assign w_sel_next = eab_sel(w_op_next, w_irq_next[11]);

  always_comb begin
    w_ctrl_next = '0;
    if (w_state_next != ST_IDLE) begin
      w_ctrl_next.busy     = 1'b1;
      w_ctrl_next.sel_eab1 = w_sel_next[2];
      w_ctrl_next.sel_eab2 = w_sel_next[1:0];
    end
    case (w_state_next)
      ST_ADDR: begin
        case (w_op_next)
          OP_BR:  w_ctrl_next.ld_pc = |(w_irq_next[11:9] & nzp);
          OP_JMP: w_ctrl_next.ld_pc = 1'b1;
          OP_JSR: begin
            w_ctrl_next.ld_pc = 1'b1;
            w_ctrl_next.ld_r7 = 1'b1;
          end
          OP_LEA: w_ctrl_next.ld_reg = 1'b1;
          OP_LD, OP_ST, OP_LDR, OP_STR, OP_LDI, OP_STI: w_ctrl_next.ld_mar = 1'b1;
          default: w_ctrl_next.err = 1'b1;
        endcase
      end
      ST_MEM1: begin
        w_ctrl_next.mem_en = 1'b1;
        w_ctrl_next.mem_we = (w_op_next == OP_ST) || (w_op_next == OP_STR);
      end
      ST_IND: begin
        w_ctrl_next.ld_mar  = 1'b1;
        w_ctrl_next.mar_src = 1'b1;
      end
      ST_MEM2: begin
        w_ctrl_next.mem_en = 1'b1;
        w_ctrl_next.mem_we = (w_op_next == OP_STI);
      end
      ST_WB:   w_ctrl_next.ld_reg = 1'b1;
      ST_DONE: w_ctrl_next.done   = 1'b1;
      default: w_ctrl_next.err    = w_abort;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_irq   <= '0;
      r_cnt   <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_state_next;
      r_irq   <= w_irq_next;
      r_cnt   <= w_cnt_next;
      r_ctrl  <= w_ctrl_next;
    end
  end

  assign selEAB1   = r_ctrl.sel_eab1;
  assign selEAB2   = r_ctrl.sel_eab2;
  assign ldMAR     = r_ctrl.ld_mar;
  assign selMARsrc = r_ctrl.mar_src;
  assign ldPC      = r_ctrl.ld_pc;
  assign ldR7      = r_ctrl.ld_r7;
  assign ldReg     = r_ctrl.ld_reg;
  assign memEn     = r_ctrl.mem_en;
  assign memWE     = r_ctrl.mem_we;
  assign busy      = r_ctrl.busy;
  assign done      = r_ctrl.done;
  assign err       = r_ctrl.err;

endmodule
